// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match logic.
//   - Screen goal columns (MIN_H / MAX_H), also used by the ball and paddle units.
//   - Match state encodings as plain localparams (for display/debug consumers)
//     and as an enum type for the controller FSM.
package pong_pkg;

  // Goal columns: player 1 defends MIN_H, player 2 defends MAX_H.
  localparam logic [8:0] MIN_H = 9'd0;
  localparam logic [8:0] MAX_H = 9'd320;

  // Match state encodings.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_SERVE = SERVE,
    ST_PLAY  = PLAY,
    ST_POINT = POINT,
    ST_OVER  = OVER
  } state_t;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational paddle coverage test.
// Reports whether the ball row lies within the rows covered by a paddle,
// i.e. paddle_y <= ball_y <= paddle_y + PADDLE_LEN - 1.
// Ports:
//   ball_y   (in,  9) current ball row
//   paddle_y (in,  9) top row of the paddle
//   in_span  (out, 1) high when the ball row is covered by the paddle
module paddle_hit_check #(
  parameter int PADDLE_LEN = 16
) (
  input  logic [8:0] ball_y,
  input  logic [8:0] paddle_y,
  output logic       in_span
);

  // Bounds are computed in 10 bits so a paddle near the bottom of the
  // 9-bit range cannot wrap its last row back to the top.
  logic [9:0] top_row;
  logic [9:0] bottom_row;
  logic [9:0] ball_row;

  assign top_row    = {1'b0, paddle_y};
  assign bottom_row = top_row + 10'(PADDLE_LEN) - 10'd1;
  assign ball_row   = {1'b0, ball_y};
  assign in_span    = (ball_row >= top_row) && (ball_row <= bottom_row);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer.
// Holds the ball at its start position during serves, issues one ball step
// per frame during play, detects missed returns at either goal column,
// keeps both scores and declares the winner.
// Ports:
//   clock       (in)     system clock
//   reset       (in)     synchronous, active-low
//   frame_tick  (in)     one-cycle strobe per game frame
//   start       (in)     level button, rising edge detected internally
//   ball_x/y    (in, 9)  current ball column / row
//   player_1_y  (in, 9)  top row of paddle 1 (left goal)
//   player_2_y  (in, 9)  top row of paddle 2 (right goal)
//   ball_rst    (out)    registered; holds the ball unit at start position
//   ball_step   (out)    registered; one-cycle advance strobe
//   score_1/2   (out, 4) player scores
//   game_over   (out)    high while the match is over
//   winner      (out)    0 = player 1, 1 = player 2; valid with game_over
//   state_o     (out, 3) current state encoding
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_LEN   = 16,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [8:0] player_1_y,
  input  logic [8:0] player_2_y,
  output logic       ball_rst,
  output logic       ball_step,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_o
);

  localparam int         CNT_W      = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
  logic [3:0]       score_1_reg, score_1_next;
  logic [3:0]       score_2_reg, score_2_next;
  logic             scorer_reg, scorer_next;    // who scored the point being judged
  logic             winner_reg, winner_next;
  logic             ball_rst_reg, ball_rst_next;
  logic             ball_step_reg, ball_step_next;
  logic             game_over_reg, game_over_next;
  logic             start_q_reg;
  logic             start_edge;

  // Paddle coverage, index 0 = player 1, index 1 = player 2.
  logic [8:0] paddle_y_arr [2];
  logic [1:0] in_span;
  logic       miss_1;
  logic       miss_2;

  assign paddle_y_arr[0] = player_1_y;
  assign paddle_y_arr[1] = player_2_y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      paddle_hit_check #(
        .PADDLE_LEN(PADDLE_LEN)
      ) u_hit (
        .ball_y  (ball_y),
        .paddle_y(paddle_y_arr[gi]),
        .in_span (in_span[gi])
      );
    end
  endgenerate

  assign miss_1     = (ball_x == MIN_H) && !in_span[0];
  assign miss_2     = (ball_x == MAX_H) && !in_span[1];
  assign start_edge = start & ~start_q_reg;

  always_comb begin
    state_next     = state_reg;
    serve_cnt_next = serve_cnt_reg;
    score_1_next   = score_1_reg;
    score_2_next   = score_2_reg;
    scorer_next    = scorer_reg;
    winner_next    = winner_reg;
    ball_step_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_edge) begin
          score_1_next   = 4'd0;
          score_2_next   = 4'd0;
          serve_cnt_next = '0;
          state_next     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_reg == SERVE_LAST) begin
            serve_cnt_next = '0;
            state_next     = ST_PLAY;
          end else begin
            serve_cnt_next = serve_cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // A miss on this frame suppresses the step so the ball never
        // advances past the goal column.
        if (frame_tick) begin
          if (miss_1) begin
            score_2_next = score_2_reg + 4'd1;
            scorer_next  = 1'b1;
            state_next   = ST_POINT;
          end else if (miss_2) begin
            score_1_next = score_1_reg + 4'd1;
            scorer_next  = 1'b0;
            state_next   = ST_POINT;
          end else begin
            ball_step_next = 1'b1;
          end
        end
      end
      ST_POINT: begin
        if ((scorer_reg ? score_2_reg : score_1_reg) == WIN_VAL) begin
          winner_next = scorer_reg;
          state_next  = ST_OVER;
        end else begin
          serve_cnt_next = '0;
          state_next     = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          score_1_next   = 4'd0;
          score_2_next   = 4'd0;
          serve_cnt_next = '0;
          state_next     = ST_SERVE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered so they line up
    // with state_o on the same cycle.
    ball_rst_next  = (state_next != ST_PLAY);
    game_over_next = (state_next == ST_OVER);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      serve_cnt_reg <= '0;
      score_1_reg   <= 4'd0;
      score_2_reg   <= 4'd0;
      scorer_reg    <= 1'b0;
      winner_reg    <= 1'b0;
      ball_rst_reg  <= 1'b1;
      ball_step_reg <= 1'b0;
      game_over_reg <= 1'b0;
      start_q_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      serve_cnt_reg <= serve_cnt_next;
      score_1_reg   <= score_1_next;
      score_2_reg   <= score_2_next;
      scorer_reg    <= scorer_next;
      winner_reg    <= winner_next;
      ball_rst_reg  <= ball_rst_next;
      ball_step_reg <= ball_step_next;
      game_over_reg <= game_over_next;
      start_q_reg   <= start;
    end
  end

  assign ball_rst  = ball_rst_reg;
  assign ball_step = ball_step_reg;
  assign score_1   = score_1_reg;
  assign score_2   = score_2_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed testbench for pong_match_ctrl (SERVE_FRAMES=4, WIN_SCORE=9,
// PADDLE_LEN=16). Inputs change 1 ns after the rising edge and outputs are
// checked at that same point, well clear of the next edge.
module tb_pong_match_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [8:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] player_1_y;
  logic [8:0] player_2_y;
  logic       ball_rst;
  logic       ball_step;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       game_over;
  logic       winner;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pong_match_ctrl #(
    .PADDLE_LEN  (16),
    .SERVE_FRAMES(4),
    .WIN_SCORE   (9)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_tick(frame_tick),
    .start     (start),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .player_1_y(player_1_y),
    .player_2_y(player_2_y),
    .ball_rst  (ball_rst),
    .ball_step (ball_step),
    .score_1   (score_1),
    .score_2   (score_2),
    .game_over (game_over),
    .winner    (winner),
    .state_o   (state_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with frame_tick set to ft during it.
  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  // From SERVE: four frame ticks bring the match into PLAY.
  task automatic serve_to_play();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  // Miss at a goal (side 1 = left / player 1 misses, 2 = right / player 2
  // misses), then the POINT cycle. Ball is returned to mid-field afterwards.
  task automatic do_miss(input int side);
    if (side == 1) begin
      ball_x = 9'd0; ball_y = 9'd106; player_1_y = 9'd90;
    end else begin
      ball_x = 9'd320; ball_y = 9'd50; player_2_y = 9'd51;
    end
    cyc(1'b1);
    ball_x = 9'd160;
    cyc(1'b0);
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    ball_x = 9'd160; ball_y = 9'd100; player_1_y = 9'd90; player_2_y = 9'd90;

    // Power-on reset
    repeat (3) cyc(1'b0);
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_ball_rst", 16'(ball_rst), 16'd1);
    chk("rst_ball_step", 16'(ball_step), 16'd0);
    chk("rst_score_1", 16'(score_1), 16'd0);
    chk("rst_score_2", 16'(score_2), 16'd0);
    chk("rst_game_over", 16'(game_over), 16'd0);
    chk("rst_winner", 16'(winner), 16'd0);
    reset = 1'b1;
    cyc(1'b1);
    chk("idle_ignores_tick", 16'(state_o), 16'd0);

    // Start edge -> SERVE
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    chk("start_serve_state", 16'(state_o), 16'd1);
    chk("start_serve_rst", 16'(ball_rst), 16'd1);

    // Serve lasts exactly 4 frame ticks
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("serve_hold_state", 16'(state_o), 16'd1);
      chk("serve_hold_rst", 16'(ball_rst), 16'd1);
      cyc(1'b0);
    end
    cyc(1'b1);
    chk("serve_done_state", 16'(state_o), 16'd2);
    chk("serve_done_rst", 16'(ball_rst), 16'd0);
    chk("serve_done_step", 16'(ball_step), 16'd0);
    cyc(1'b0);
    chk("play_no_tick_step", 16'(ball_step), 16'd0);
    cyc(1'b1);
    chk("first_step", 16'(ball_step), 16'd1);
    cyc(1'b0);
    chk("step_one_cycle", 16'(ball_step), 16'd0);

    // Hits at the left goal: mid paddle, last row, top row
    ball_x = 9'd0; ball_y = 9'd100; player_1_y = 9'd90;
    cyc(1'b1);
    chk("hit_mid_step", 16'(ball_step), 16'd1);
    chk("hit_mid_score_2", 16'(score_2), 16'd0);
    chk("hit_mid_state", 16'(state_o), 16'd2);
    ball_y = 9'd105;
    cyc(1'b1);
    chk("hit_last_row_step", 16'(ball_step), 16'd1);
    chk("hit_last_row_score_2", 16'(score_2), 16'd0);
    ball_y = 9'd90;
    cyc(1'b1);
    chk("hit_top_row_score_2", 16'(score_2), 16'd0);
    // Off-goal column: no miss regardless of paddle
    ball_x = 9'd1; ball_y = 9'd300;
    cyc(1'b1);
    chk("off_goal_state", 16'(state_o), 16'd2);

    // Miss one row past the paddle
    ball_x = 9'd0; ball_y = 9'd106; player_1_y = 9'd90;
    cyc(1'b1);
    chk("miss1_state_point", 16'(state_o), 16'd3);
    chk("miss1_score_2", 16'(score_2), 16'd1);
    chk("miss1_no_step", 16'(ball_step), 16'd0);
    chk("miss1_ball_rst", 16'(ball_rst), 16'd1);
    ball_x = 9'd160;
    cyc(1'b0);
    chk("miss1_back_serve", 16'(state_o), 16'd1);
    chk("miss1_serve_rst", 16'(ball_rst), 16'd1);

    // Miss one row above the paddle
    serve_to_play();
    ball_x = 9'd0; ball_y = 9'd89;
    cyc(1'b1);
    chk("miss_above_score_2", 16'(score_2), 16'd2);
    ball_x = 9'd160;
    cyc(1'b0);

    // Three right-side misses -> score_1 = 3, then reset mid-PLAY
    for (int i = 0; i < 3; i++) begin
      serve_to_play();
      do_miss(2);
    end
    serve_to_play();
    chk("pre_reset_state", 16'(state_o), 16'd2);
    chk("pre_reset_score_1", 16'(score_1), 16'd3);
    reset = 1'b0;
    cyc(1'b1);
    chk("midplay_rst_state", 16'(state_o), 16'd0);
    chk("midplay_rst_step", 16'(ball_step), 16'd0);
    cyc(1'b0);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b0);
    chk("post_reset_state", 16'(state_o), 16'd0);
    chk("post_reset_score_1", 16'(score_1), 16'd0);
    chk("post_reset_score_2", 16'(score_2), 16'd0);
    chk("post_reset_ball_rst", 16'(ball_rst), 16'd1);
    chk("post_reset_step", 16'(ball_step), 16'd0);

    // New match: player 2 misses 8 times -> score_1 = 8
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serve_to_play();
      do_miss(2);
    end
    chk("score_1_eight", 16'(score_1), 16'd8);
    chk("score_1_eight_state", 16'(state_o), 16'd1);
    serve_to_play();

    // Start edge during PLAY is ignored
    start = 1'b1;
    cyc(1'b0);
    chk("play_start_state", 16'(state_o), 16'd2);
    chk("play_start_score_1", 16'(score_1), 16'd8);
    start = 1'b0;
    cyc(1'b0);

    // Ninth point wins for player 1
    ball_x = 9'd320; ball_y = 9'd50; player_2_y = 9'd51;
    cyc(1'b1);
    chk("win_point_state", 16'(state_o), 16'd3);
    chk("win_point_score_1", 16'(score_1), 16'd9);
    ball_x = 9'd160;
    cyc(1'b0);
    chk("over_state", 16'(state_o), 16'd4);
    chk("over_game_over", 16'(game_over), 16'd1);
    chk("over_winner", 16'(winner), 16'd0);
    chk("over_ball_rst", 16'(ball_rst), 16'd1);
    cyc(1'b1);
    chk("over_frozen_score_1", 16'(score_1), 16'd9);
    chk("over_hold_state", 16'(state_o), 16'd4);

    // Start held high: exactly one restart
    start = 1'b1;
    cyc(1'b0);
    chk("restart_state", 16'(state_o), 16'd1);
    chk("restart_score_1", 16'(score_1), 16'd0);
    chk("restart_game_over", 16'(game_over), 16'd0);
    serve_to_play();
    do_miss(1);
    chk("held_start_score_2", 16'(score_2), 16'd1);
    chk("held_start_state", 16'(state_o), 16'd1);
    start = 1'b0;

    // Player 2 wins: eight more left-side misses
    for (int i = 0; i < 8; i++) begin
      serve_to_play();
      do_miss(1);
    end
    chk("p2_win_score_2", 16'(score_2), 16'd9);
    chk("p2_win_score_1", 16'(score_1), 16'd0);
    chk("p2_win_state", 16'(state_o), 16'd4);
    chk("p2_win_winner", 16'(winner), 16'd1);
    chk("p2_win_game_over", 16'(game_over), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for Pong: owns the ball's reset and step enable, detects missed returns at either goal line, keeps both scores and declares the winner.
- Sits between the frame-rate tick generator and the ball/paddle datapath. The ball unit advances only when this block issues ball_step.
- The ball unit is returned to its start position via ball_rst on every serve.

Parameters:
- MIN_H, 0, left goal column (player 1 side).
- MAX_H, 320, right goal column (player 2 side).
- PADDLE_LEN, 16, paddle height in pixels; paddle covers paddle_y .. paddle_y+PADDLE_LEN-1.
- SERVE_FRAMES, 60, frame ticks the ball is held at centre before play resumes.
- WIN_SCORE, 9, points needed to win; must be 1..15.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, one clock; reset is synchronous and active-low.
- frame_tick, input, 1, one-cycle strobe per game frame.
- start, input, 1, level button; rising edge detected internally.
- ball_x, input, 9, current ball column.
- ball_y, input, 9, current ball row.
- player_1_y, input, 9, top row of paddle 1.
- player_2_y, input, 9, top row of paddle 2.
- ball_rst, output, 1, registered; holds the ball unit at its start position.
- ball_step, output, 1, registered; one-cycle advance strobe to the ball unit.
- score_1, output, 4, player 1 points.
- score_2, output, 4, player 2 points.
- game_over, output, 1, high in OVER.
- winner, output, 1, 0 = player 1, 1 = player 2; valid when game_over is high.
- state_o, output, 3, current state encoding, for debug and display.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, score_1=0, score_2=0, ball_rst=1, ball_step=0, game_over=0, winner=0.
  - Serve counter=0, start edge register=0.
  - Applies from any state, including mid-PLAY; it overrides every other event in that cycle.
- start_edge = start & ~start_q. The start_q register is updated every cycle.
- IDLE:
  - ball_rst=1, ball_step=0.
  - On start_edge: clear both scores, serve counter=0, go to SERVE.
- SERVE:
  - ball_rst=1, ball_step=0.
  - The counter increments on each frame_tick.
  - When counter==SERVE_FRAMES-1 and frame_tick is high: counter=0, ball_rst=0 on the next cycle, go to PLAY.
- PLAY:
  - ball_rst=0; ball_step=frame_tick, registered, so 1-cycle latency.
  - Miss check is evaluated only in cycles where frame_tick is high, before the step is issued, using the current ball and paddle inputs.
  - Player 1 misses when ball_x==MIN_H and (ball_y < player_1_y or ball_y > player_1_y+PADDLE_LEN-1). Then score_2++ and go to POINT; no ball_step is issued that frame.
  - Player 2 misses when ball_x==MAX_H with the same test against player_2_y. Then score_1++ and go to POINT.
  - Paddle bound arithmetic is 10-bit so player_y+PADDLE_LEN cannot wrap.
  - A hit produces no action here; the ball unit reflects the ball itself.
  - ball_x can match only one goal per cycle, so a simultaneous double miss is impossible.
- POINT (exactly 1 cycle):
  - ball_rst=1.
  - If the updated score equals WIN_SCORE: winner is set to the scorer, go to OVER.
  - Otherwise: serve counter=0, go to SERVE.
- OVER:
  - ball_rst=1, game_over=1; scores frozen.
  - On start_edge: clear scores, game_over=0, go to SERVE (new match).
- start_edge is ignored in SERVE, PLAY and POINT.
- frame_tick is ignored outside SERVE and PLAY.
- Scores never exceed WIN_SCORE; no wrap is possible.
- Unused state encodings go to IDLE.

Decomposition:
- Package pong_pkg holds:
  - State encoding localparams: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
  - Shared screen constants MIN_H and MAX_H, also used by the ball and paddle units.
- One natural sub-module, paddle_hit_check: combinational; takes ball_y, paddle_y and PADDLE_LEN, returns in_span. It is instantiated twice, once per player.

Test Plan:
- Reset held low for 3 cycles mid-PLAY with score_1=3 -> next cycle state=IDLE, scores 0, ball_rst=1, ball_step=0.
- start rising edge in IDLE, SERVE_FRAMES=4 -> ball_rst stays 1 for exactly 4 frame_ticks; the first ball_step arrives one cycle after the 5th frame_tick.
- PLAY, ball_x=0, ball_y=100, player_1_y=90, frame_tick -> hit: scores unchanged, ball_step=1 next cycle.
- PLAY, ball_x=0, ball_y=106, player_1_y=90 (106 is 1 past the paddle's last row, 105) -> score_2 becomes 1, no ball_step, POINT then SERVE with ball_rst=1.
- PLAY, ball_x=320, ball_y=50, player_2_y=51 -> score_1++. With score_1 previously 8 and WIN_SCORE=9 -> OVER, game_over=1, winner=0.
- OVER, start held high continuously -> exactly one restart; scores cleared once. A start edge asserted during PLAY leaves scores and state unchanged.
